// File: rtl/match_ctrl_pkg.sv
// rtl/match_ctrl_pkg.sv - shared types and constants for the pong match sequencer and score renderer
package match_ctrl_pkg;

    // Pre-existing two-state control type, still used elsewhere in the pipeline
    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    typedef enum logic [1:0] {
        GS_WAIT_START = 2'd0,
        GS_SERVE      = 2'd1,
        GS_PLAY       = 2'd2,
        GS_GAME_OVER  = 2'd3
    } game_state_e;

    localparam int MAX_SCORE    = 5;
    localparam int SERVE_FRAMES = 60;
    localparam int M_SCORE_W    = 4;

    // 3x5 glyph font, row 0 at the top, column 0 at the left
    localparam int SCORE_W = 3;
    localparam int SCORE_H = 5;
    localparam int POS_W   = 10;

    typedef logic [0:SCORE_H-1][0:SCORE_W-1] glyph_t;

    typedef struct packed {
        logic [POS_W-1:0] x_pos;
        logic [POS_W-1:0] y_pos;
        glyph_t           score_val;
    } score_t;

    localparam logic [POS_W-1:0] P_SCORE_X = 10'd280;
    localparam logic [POS_W-1:0] P_SCORE_Y = 10'd16;
    localparam logic [POS_W-1:0] E_SCORE_X = 10'd344;
    localparam logic [POS_W-1:0] E_SCORE_Y = 10'd16;

    localparam glyph_t score0 = 15'b111_101_101_101_111;
    localparam glyph_t score1 = 15'b010_110_010_010_111;
    localparam glyph_t score2 = 15'b111_001_111_100_111;
    localparam glyph_t score3 = 15'b111_001_111_001_111;
    localparam glyph_t score4 = 15'b101_101_111_001_001;
    localparam glyph_t score5 = 15'b111_100_111_001_111;
    localparam glyph_t score6 = 15'b111_100_111_101_111;
    localparam glyph_t score7 = 15'b111_001_001_001_001;
    localparam glyph_t score8 = 15'b111_101_111_101_111;
    localparam glyph_t score9 = 15'b111_101_111_001_111;

endpackage

// File: rtl/match_ctrl_if.sv
// rtl/match_ctrl_if.sv - control and score signals between the match sequencer and its surroundings
interface match_ctrl_if;
    import match_ctrl_pkg::*;

    logic        start_i;
    logic        frame_tick_i;
    logic        p_goal_i;
    logic        e_goal_i;
    logic        ball_rst_o;
    logic        ball_hold_o;
    game_state_e state_o;
    logic        game_over_o;
    logic        p_wins_o;
    score_t      p_score_o;
    score_t      e_score_o;

    modport master (
        output start_i, frame_tick_i, p_goal_i, e_goal_i,
        input  ball_rst_o, ball_hold_o, state_o, game_over_o, p_wins_o, p_score_o, e_score_o
    );

    modport slave (
        input  start_i, frame_tick_i, p_goal_i, e_goal_i,
        output ball_rst_o, ball_hold_o, state_o, game_over_o, p_wins_o, p_score_o, e_score_o
    );

endinterface

// File: rtl/match_ctrl_score_glyph_rom.sv
// rtl/match_ctrl_score_glyph_rom.sv - decimal digit to 3x5 glyph lookup
module score_glyph_rom
    import match_ctrl_pkg::*;
(
    input  logic [M_SCORE_W-1:0] digit,
    output glyph_t               glyph
);

    // Digit select; codes above 9 render blank
    always_comb begin
        glyph = '0;
        case (digit)
            4'd0: glyph = score0;
            4'd1: glyph = score1;
            4'd2: glyph = score2;
            4'd3: glyph = score3;
            4'd4: glyph = score4;
            4'd5: glyph = score5;
            4'd6: glyph = score6;
            4'd7: glyph = score7;
            4'd8: glyph = score8;
            4'd9: glyph = score9;
            default: glyph = '0;
        endcase
    end

endmodule

// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - pong match sequencer: point counters, serve delay and score records
module match_ctrl
    import match_ctrl_pkg::*;
#(
    parameter int MAX_SCORE_P  = MAX_SCORE,
    parameter int SERVE_FRAMES_P = SERVE_FRAMES,
    parameter int SERVE_CNT_W  = $clog2(SERVE_FRAMES_P + 1)
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    match_ctrl_if.slave  mif
);

    localparam logic [M_SCORE_W-1:0]   MAX_CNT    = M_SCORE_W'(MAX_SCORE_P);
    localparam logic [SERVE_CNT_W-1:0] SERVE_LAST = SERVE_CNT_W'(SERVE_FRAMES_P - 1);

    game_state_e            state_q, state_d;
    logic [M_SCORE_W-1:0]   p_cnt_q, p_cnt_d, e_cnt_q, e_cnt_d;
    logic [SERVE_CNT_W-1:0] serve_cnt_q, serve_cnt_d;
    logic                   p_wins_q, p_wins_d;
    logic                   ball_rst_q, ball_rst_d;
    logic                   start_q;
    logic                   start_pe;
    logic [M_SCORE_W-1:0]   p_inc, e_inc;
    glyph_t                 p_glyph, e_glyph;

    assign start_pe = mif.start_i & ~start_q;
    assign p_inc    = p_cnt_q + 1'b1;
    assign e_inc    = e_cnt_q + 1'b1;

    // All match state; start_q resets high so a button held through reset is not an edge
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= GS_WAIT_START;
            p_cnt_q     <= '0;
            e_cnt_q     <= '0;
            serve_cnt_q <= '0;
            p_wins_q    <= 1'b0;
            ball_rst_q  <= 1'b0;
            start_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_cnt_q     <= p_cnt_d;
            e_cnt_q     <= e_cnt_d;
            serve_cnt_q <= serve_cnt_d;
            p_wins_q    <= p_wins_d;
            ball_rst_q  <= ball_rst_d;
            start_q     <= mif.start_i;
        end
    end

    // Next state, counters and the ball re-centre request
    always_comb begin
        state_d     = state_q;
        p_cnt_d     = p_cnt_q;
        e_cnt_d     = e_cnt_q;
        serve_cnt_d = serve_cnt_q;
        p_wins_d    = p_wins_q;
        ball_rst_d  = 1'b0;
        case (state_q)
            GS_WAIT_START, GS_GAME_OVER: begin
                if (start_pe) begin
                    p_cnt_d    = '0;
                    e_cnt_d    = '0;
                    p_wins_d   = 1'b0;
                    state_d    = GS_SERVE;
                    ball_rst_d = 1'b1;
                end
            end
            GS_SERVE: begin
                if (mif.frame_tick_i) begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        serve_cnt_d = '0;
                        state_d     = GS_PLAY;
                    end else begin
                        serve_cnt_d = serve_cnt_q + 1'b1;
                    end
                end
            end
            GS_PLAY: begin
                // Simultaneous goals replay the point without scoring
                if (mif.p_goal_i && mif.e_goal_i) begin
                    state_d    = GS_SERVE;
                    ball_rst_d = 1'b1;
                end else if (mif.p_goal_i) begin
                    p_cnt_d = p_inc;
                    if (p_inc == MAX_CNT) begin
                        state_d  = GS_GAME_OVER;
                        p_wins_d = 1'b1;
                    end else begin
                        state_d    = GS_SERVE;
                        ball_rst_d = 1'b1;
                    end
                end else if (mif.e_goal_i) begin
                    e_cnt_d = e_inc;
                    if (e_inc == MAX_CNT) begin
                        state_d  = GS_GAME_OVER;
                        p_wins_d = 1'b0;
                    end else begin
                        state_d    = GS_SERVE;
                        ball_rst_d = 1'b1;
                    end
                end
            end
            default: state_d = GS_WAIT_START;
        endcase
    end

    score_glyph_rom u_p_glyph (.digit(p_cnt_q), .glyph(p_glyph));
    score_glyph_rom u_e_glyph (.digit(e_cnt_q), .glyph(e_glyph));

    // State-decoded outputs and the score records for the renderer
    always_comb begin
        mif.ball_hold_o = (state_q != GS_PLAY);
        mif.game_over_o = (state_q == GS_GAME_OVER);
        mif.state_o     = state_q;
        mif.ball_rst_o  = ball_rst_q;
        mif.p_wins_o    = p_wins_q;
        mif.p_score_o   = '{x_pos: P_SCORE_X, y_pos: P_SCORE_Y, score_val: p_glyph};
        mif.e_score_o   = '{x_pos: E_SCORE_X, y_pos: E_SCORE_Y, score_val: e_glyph};
    end

endmodule
